// File: rtl/fir9_cfg_ctrl.sv
// ============================================================================
// Module   : fir9_cfg_ctrl
// Purpose  : Shadow/active configuration bank and commit/flush sequencer for
//            the 9-tap thresholding FIR. Optional readback: FIR9_CFG_READBACK_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module fir9_cfg_ctrl #(
  parameter int TAPS         = 9,
  parameter int FLUSH_CYCLES = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [3:0]          i_wr_addr,
  input  logic [10:0]         i_wr_data,
  output logic                o_wr_err,
  input  logic                i_s_valid,
  input  logic [3:0]          i_s_data,
  output logic [3:0]          o_fir_x,
  output logic [4*TAPS-1:0]   o_fir_c,
  output logic [10:0]         o_fir_thresh,
  input  logic                i_fir_y,
  output logic                o_y,
  output logic                o_y_valid,
  output logic                o_busy,
  output logic                o_cfg_dirty
`ifdef FIR9_CFG_READBACK_EN
  ,
  input  logic [3:0]          i_rd_addr,
  input  logic                i_rd_shadow,
  output logic [10:0]         o_rd_data
`endif
);

  localparam int              c_CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(FLUSH_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);
  localparam logic [3:0]      c_ADDR_THR = 4'(TAPS);
  localparam logic [3:0]      c_ADDR_CMT = 4'(TAPS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_wr_err;
  logic [3:0]           r_fir_x;
  logic                 r_dirty;
  logic [3:0]           r_sh_c  [TAPS];
  logic [3:0]           r_act_c [TAPS];
  logic [10:0]          r_sh_thr;
  logic [10:0]          r_act_thr;

  logic                 w_idle;
  logic                 w_is_coef;

  assign w_idle    = (r_state == S_IDLE);
  assign w_is_coef = (i_wr_addr < c_ADDR_THR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FLUSH;
      r_cnt     <= c_CNT_INIT;
      r_wr_err  <= 1'b0;
      r_fir_x   <= '0;
      r_dirty   <= 1'b0;
      r_sh_thr  <= '0;
      r_act_thr <= '0;
      for (int i = 0; i < TAPS; i++) begin
        r_sh_c[i]  <= '0;
        r_act_c[i] <= '0;
      end
    end else begin
      r_wr_err <= 1'b0;
      // Only IDLE forwards samples; COMMIT and FLUSH feed zeros into the taps.
      r_fir_x  <= (w_idle && i_s_valid) ? i_s_data : 4'd0;

      case (r_state)
        S_IDLE: begin
          if (i_wr_valid) begin
            if (w_is_coef) begin
              for (int i = 0; i < TAPS; i++) begin
                if (i_wr_addr == 4'(i)) begin
                  r_sh_c[i] <= i_wr_data[3:0];
                end
              end
              r_dirty <= 1'b1;
            end else if (i_wr_addr == c_ADDR_THR) begin
              r_sh_thr <= i_wr_data;
              r_dirty  <= 1'b1;
            end else if (i_wr_addr == c_ADDR_CMT) begin
              r_state <= S_COMMIT;
            end else begin
              r_wr_err <= 1'b1;
            end
          end
        end

        S_COMMIT: begin
          for (int i = 0; i < TAPS; i++) begin
            r_act_c[i] <= r_sh_c[i];
          end
          r_act_thr <= r_sh_thr;
          r_dirty   <= 1'b0;
          r_cnt     <= c_CNT_INIT;
          r_state   <= S_FLUSH;
        end

        S_FLUSH: begin
          r_cnt <= r_cnt - c_CNT_LAST;
          if (r_cnt <= c_CNT_LAST) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_FLUSH;
          r_cnt   <= c_CNT_INIT;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_pack
    assign o_fir_c[4*gi +: 4] = r_act_c[gi];
  end

  assign o_wr_ready   = w_idle;
  assign o_wr_err     = r_wr_err;
  assign o_fir_x      = r_fir_x;
  assign o_fir_thresh = r_act_thr;
  assign o_y_valid    = w_idle;
  assign o_y          = i_fir_y & w_idle;
  assign o_busy       = ~w_idle;
  assign o_cfg_dirty  = r_dirty;

`ifdef FIR9_CFG_READBACK_EN
  logic [10:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= '0;
      if (i_rd_addr == c_ADDR_THR) begin
        r_rd_data <= i_rd_shadow ? r_sh_thr : r_act_thr;
      end else begin
        for (int i = 0; i < TAPS; i++) begin
          if (i_rd_addr == 4'(i)) begin
            r_rd_data <= {7'd0, (i_rd_shadow ? r_sh_c[i] : r_act_c[i])};
          end
        end
      end
    end
  end

  assign o_rd_data = r_rd_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir9_cfg_ctrl.sv
// ============================================================================
// Module   : tb_fir9_cfg_ctrl
// Purpose  : Directed self-checking bench for fir9_cfg_ctrl with a FIR model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fir9_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [10:0] wr_data;
  logic        wr_err;
  logic        s_valid;
  logic [3:0]  s_data;
  logic [3:0]  fir_x;
  logic [35:0] fir_c;
  logic [10:0] fir_thresh;
  logic        fir_y;
  logic        y;
  logic        y_valid;
  logic        busy;
  logic        cfg_dirty;
`ifdef FIR9_CFG_READBACK_EN
  logic [3:0]  rd_addr = 4'd0;
  logic        rd_shadow = 1'b0;
  logic [10:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir9_cfg_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_err     (wr_err),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .o_fir_x      (fir_x),
    .o_fir_c      (fir_c),
    .o_fir_thresh (fir_thresh),
    .i_fir_y      (fir_y),
    .o_y          (y),
    .o_y_valid    (y_valid),
    .o_busy       (busy),
    .o_cfg_dirty  (cfg_dirty)
`ifdef FIR9_CFG_READBACK_EN
    ,
    .i_rd_addr    (rd_addr),
    .i_rd_shadow  (rd_shadow),
    .o_rd_data    (rd_data)
`endif
  );

  // Behavioural FIR: delay line fed by fir_x, output = dot product > threshold.
  logic [3:0] m_taps [9];
  int         m_sum;

  always @(posedge clk) begin
    for (int i = 8; i > 0; i--) m_taps[i] <= m_taps[i-1];
    m_taps[0] <= fir_x;
  end

  always_comb begin
    m_sum = 0;
    for (int i = 0; i < 9; i++) m_sum += int'(m_taps[i]) * int'(fir_c[4*i +: 4]);
    fir_y = (m_sum > int'(fir_thresh));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [10:0] d);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!wr_ready) chk("wr_timeout", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic check_blanking(input string tag);
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_yv"},   64'(y_valid), 64'd0);
      tick();
    end
    chk({tag, "_ready"}, 64'(wr_ready), 64'd1);
    chk({tag, "_yv_on"}, 64'(y_valid), 64'd1);
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 11'd0;
    s_valid  = 1'b0;
    s_data   = 4'd0;
    tick(); tick(); tick();

    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_wr_err",   64'(wr_err), 64'd0);
    chk("rst_fir_x",    64'(fir_x), 64'd0);
    chk("rst_fir_c",    64'(fir_c), 64'd0);
    chk("rst_thresh",   64'(fir_thresh), 64'd0);
    chk("rst_y",        64'(y), 64'd0);
    chk("rst_y_valid",  64'(y_valid), 64'd0);
    chk("rst_busy",     64'(busy), 64'd1);
    chk("rst_dirty",    64'(cfg_dirty), 64'd0);

    rst = 1'b0;
    check_blanking("init");
    chk("init_fir_c",  64'(fir_c), 64'd0);
    chk("init_thresh", 64'(fir_thresh), 64'd0);

    // Load all-ones coefficients and threshold 20, then commit.
    do_write(4'd0, 11'd1);
    chk("dirty_set", 64'(cfg_dirty), 64'd1);
    for (int i = 1; i < 9; i++) do_write(4'(i), 11'd1);
    do_write(4'd9, 11'd20);
    chk("shadow_no_leak", 64'(fir_c), 64'd0);
    do_write(4'd10, 11'd0);
    chk("commit_c_hold", 64'(fir_c), 64'd0);
    chk("commit_busy",   64'(busy), 64'd1);
    tick();
    chk("commit_c_new",  64'(fir_c), 64'h1_1111_1111);
    chk("commit_thresh", 64'(fir_thresh), 64'd20);
    chk("commit_dirty",  64'(cfg_dirty), 64'd0);
    check_blanking("cmt1");

    // Nine samples of 3 give 27 > 20.
    chk("y_before", 64'(y), 64'd0);
    s_valid = 1'b1;
    s_data  = 4'd3;
    for (int k = 0; k < 12; k++) tick();
    chk("y_detect", 64'(y), 64'd1);
    s_valid = 1'b0;

    // Illegal address.
    wr_valid = 1'b1; wr_addr = 4'd12; wr_data = 11'd5;
    tick();
    wr_valid = 1'b0;
    chk("err_pulse", 64'(wr_err), 64'd1);
    chk("err_ready", 64'(wr_ready), 64'd1);
    tick();
    chk("err_clear",  64'(wr_err), 64'd0);
    chk("err_thresh", 64'(fir_thresh), 64'd20);
    chk("err_fir_c",  64'(fir_c), 64'h1_1111_1111);
    chk("err_dirty",  64'(cfg_dirty), 64'd0);

    // Clean commit with streaming 15s and a write held through FLUSH.
    s_valid = 1'b1;
    s_data  = 4'd15;
    tick();
    wr_valid = 1'b1; wr_addr = 4'd10; wr_data = 11'd0;
    tick();
    chk("st_fwd_last", 64'(fir_x), 64'd15);
    chk("st_ready0",   64'(wr_ready), 64'd0);
    wr_addr = 4'd0; wr_data = 11'd7;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("st_flush_x", 64'(fir_x), 64'd0);
      chk("st_stall",   64'(wr_ready), 64'd0);
    end
    tick();
    chk("st_idle_rdy", 64'(wr_ready), 64'd1);
    chk("st_idle_x",   64'(fir_x), 64'd0);
    tick();
    wr_valid = 1'b0;
    chk("st_resume_x", 64'(fir_x), 64'd15);
    chk("st_dirty",    64'(cfg_dirty), 64'd1);
    chk("st_c_hold",   64'(fir_c), 64'h1_1111_1111);
    s_valid = 1'b0;
    do_write(4'd10, 11'd0);
    tick();
    chk("st_c_new", 64'(fir_c), 64'h1_1111_1117);
    for (int k = 0; k < 10; k++) tick();
    chk("st_idle2", 64'(wr_ready), 64'd1);

    // Reset four cycles into FLUSH.
    do_write(4'd9, 11'd100);
    do_write(4'd10, 11'd0);
    tick(); tick(); tick(); tick();
    chk("rf_thresh100", 64'(fir_thresh), 64'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_thresh0", 64'(fir_thresh), 64'd0);
    chk("rf_fir_c0",  64'(fir_c), 64'd0);
    chk("rf_dirty",   64'(cfg_dirty), 64'd0);
    check_blanking("rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
